// File: rtl/mole_hit_scorer_if.sv
// Signal bundle between the whack-a-mole scorer and its surroundings.
//   enable     : game run/pause
//   led        : lit-LED vector from the generator
//   button     : raw push-buttons, 1 = pressed, asynchronous
//   hit_pulse  : one-cycle pulse, at least one hit registered
//   miss_pulse : one-cycle pulse, at least one miss registered
//   score      : total hits, saturating
//   misses     : total misses, saturating
//   level      : current difficulty, fed back to the generator
//   game_over  : high once the miss limit has been reached
// slave = scorer side, master = board/generator/display side.
interface mole_hit_scorer_if #(
   parameter int N_LANES = 18,
   parameter int SCORE_W = 10,
   parameter int LEVEL_W = 2
);
   logic               enable;
   logic [N_LANES-1:0] led;
   logic [N_LANES-1:0] button;
   logic               hit_pulse;
   logic               miss_pulse;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] misses;
   logic [LEVEL_W-1:0] level;
   logic               game_over;

   modport slave (
      input  enable, led, button,
      output hit_pulse, miss_pulse, score, misses, level, game_over
   );

   modport master (
      output enable, led, button,
      input  hit_pulse, miss_pulse, score, misses, level, game_over
   );
endinterface

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: synchronises player buttons, classifies each rising
// press as hit (LED lit, not yet hit) or miss, keeps saturating score/miss
// counts, steps the difficulty level and runs the IDLE/PLAY/OVER game state.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : mole_hit_scorer_if.slave (enable, led, button in; pulses,
//         counters, level, game_over out; all outputs registered)
//
// state  | meaning
// IDLE   | paused / not started; presses consumed but not scored
// PLAY   | scoring active
// OVER   | miss limit reached; everything frozen until rst
module mole_hit_scorer #(
   parameter int N_LANES        = 18,
   parameter int SCORE_W        = 10,
   parameter int LEVEL_W        = 2,
   parameter int MAX_LEVEL      = 3,
   parameter int HITS_PER_LEVEL = 10,
   parameter int MAX_MISSES     = 5
) (
   input logic              clk,
   input logic              rst,
   mole_hit_scorer_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;

   localparam int CNT_W = $clog2(N_LANES + 1);
   localparam logic [SCORE_W-1:0] SAT = '1;

   logic [N_LANES-1:0] sync1, sync2, prev, hit_mask;
   logic [N_LANES-1:0] press_edge, hit_vec, miss_vec;
   logic [1:0]         state, state_nx;
   logic               scoring;
   logic [CNT_W-1:0]   n_hit, n_miss;
   logic [SCORE_W-1:0] score_q, misses_q, hil;
   logic [SCORE_W-1:0] score_nx, misses_nx, hil_nx;
   logic [SCORE_W:0]   hil_sum;
   logic [LEVEL_W-1:0] level_q, level_nx;
   logic               hit_q, miss_q, over_q;

   function automatic logic [CNT_W-1:0] popcount(input logic [N_LANES-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_LANES; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [CNT_W-1:0]   b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + (SCORE_W+1)'(b);
      return s[SCORE_W] ? SAT : s[SCORE_W-1:0];
   endfunction

   always_comb begin
      press_edge = sync2 & ~prev;
      // enable is checked here too, so a press landing on the cycle that
      // enable drops is never scored
      scoring    = (state == S_PLAY) && bus.enable;
      hit_vec    = '0;
      miss_vec   = '0;
      if (scoring) begin
         hit_vec  = press_edge & bus.led & ~hit_mask;
         miss_vec = press_edge & ~(bus.led & ~hit_mask);
      end
      n_hit     = popcount(hit_vec);
      n_miss    = popcount(miss_vec);
      score_nx  = sat_add(score_q, n_hit);
      misses_nx = sat_add(misses_q, n_miss);

      // at most one level step per update; any excess stays in hil
      hil_sum  = {1'b0, hil} + (SCORE_W+1)'(n_hit);
      hil_nx   = sat_add(hil, n_hit);
      level_nx = level_q;
      if ((level_q < LEVEL_W'(MAX_LEVEL)) &&
          (hil_sum >= (SCORE_W+1)'(HITS_PER_LEVEL))) begin
         level_nx = level_q + 1'b1;
         hil_nx   = SCORE_W'(hil_sum - (SCORE_W+1)'(HITS_PER_LEVEL));
      end

      state_nx = state;
      case (state)
         S_IDLE:  if (bus.enable) state_nx = S_PLAY;
         S_PLAY: begin
            if (!bus.enable)                              state_nx = S_IDLE;
            else if (misses_nx >= SCORE_W'(MAX_MISSES))   state_nx = S_OVER;
         end
         S_OVER:  state_nx = S_OVER;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         hit_mask <= '0;
         state    <= S_IDLE;
         score_q  <= '0;
         misses_q <= '0;
         hil      <= '0;
         level_q  <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         // synchronisers and edge register run in every state so that no
         // stale edge is left behind when play starts or resumes
         sync1    <= bus.button;
         sync2    <= sync1;
         prev     <= sync2;
         hit_mask <= bus.led & (hit_mask | hit_vec);
         state    <= state_nx;
         hit_q    <= |hit_vec;
         miss_q   <= |miss_vec;
         over_q   <= (state_nx == S_OVER);
         if (scoring) begin
            score_q  <= score_nx;
            misses_q <= misses_nx;
            hil      <= hil_nx;
            level_q  <= level_nx;
         end
      end
   end

   assign bus.hit_pulse  = hit_q;
   assign bus.miss_pulse = miss_q;
   assign bus.score      = score_q;
   assign bus.misses     = misses_q;
   assign bus.level      = level_q;
   assign bus.game_over  = over_q;

endmodule

// File: tb/tb_mole_hit_scorer.sv
module tb_mole_hit_scorer;
   localparam int NL = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   mole_hit_scorer_if #(.N_LANES(NL), .SCORE_W(10), .LEVEL_W(2)) bus ();

   mole_hit_scorer #(
      .N_LANES(NL), .SCORE_W(10), .LEVEL_W(2),
      .MAX_LEVEL(3), .HITS_PER_LEVEL(10), .MAX_MISSES(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A press is scored at edge k when the button was sampled high at edge
   // k-2 and low at edge k-3 (samples at or before the last reset read 0);
   // led/enable are the values sampled at edge k.
   logic [NL-1:0] btn_at [0:16383];
   int  cyc = 0, last_rst = 0;
   bit  model_valid = 0;
   int  m_score, m_miss, m_level, m_hil, m_state;   // state 0 idle 1 play 2 over
   bit  m_hp, m_mp, m_go;
   bit  [NL-1:0] m_lit_hit;

   function automatic logic [NL-1:0] b_at(input int j);
      if (j <= last_rst) return '0;
      return btn_at[j];
   endfunction

   function automatic int sat(input int v);
      return (v > 1023) ? 1023 : v;
   endfunction

   always @(posedge clk) begin
      logic [NL-1:0] pe, hl;
      int h, mi;
      bit active;
      cyc++;
      if (rst) begin
         last_rst = cyc; btn_at[cyc] = '0; model_valid = 1;
         m_score = 0; m_miss = 0; m_level = 0; m_hil = 0; m_state = 0;
         m_hp = 0; m_mp = 0; m_go = 0; m_lit_hit = '0;
      end else begin
         btn_at[cyc] = bus.button;
         pe = b_at(cyc-2) & ~b_at(cyc-3);
         active = (m_state == 1) && bus.enable;
         h = 0; mi = 0; hl = '0;
         if (active)
            for (int i = 0; i < NL; i++)
               if (pe[i]) begin
                  if (bus.led[i] && !m_lit_hit[i]) begin h++; hl[i] = 1'b1; end
                  else mi++;
               end
         m_hp = (h > 0);
         m_mp = (mi > 0);
         if (active) begin
            m_score = sat(m_score + h);
            m_miss  = sat(m_miss + mi);
            if (m_level < 3 && m_hil + h >= 10) begin
               m_level++;
               m_hil = m_hil + h - 10;
            end else m_hil = sat(m_hil + h);
         end
         if (m_state == 0 && bus.enable) m_state = 1;
         else if (m_state == 1 && !bus.enable) m_state = 0;
         else if (m_state == 1 && m_miss >= 5) m_state = 2;
         for (int i = 0; i < NL; i++)
            m_lit_hit[i] = bus.led[i] && (m_lit_hit[i] || hl[i]);
         m_go = (m_state == 2);
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("hit_pulse",  int'(bus.hit_pulse),  int'(m_hp));
         chk("miss_pulse", int'(bus.miss_pulse), int'(m_mp));
         chk("score",      int'(bus.score),      m_score);
         chk("misses",     int'(bus.misses),     m_miss);
         chk("level",      int'(bus.level),      m_level);
         chk("game_over",  int'(bus.game_over),  int'(m_go));
      end
   end

   initial begin
      #(15000 * 20);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [NL-1:0] m, input int hold);
      bus.button = m;
      tick(hold);
      bus.button = '0;
      tick(4);
   endtask

   task automatic do_hit(input int lane);
      logic [NL-1:0] one;
      one = '0;
      one[lane] = 1'b1;
      bus.led = '0;
      tick(1);
      bus.led = one;
      press(one, 2);
   endtask

   initial begin
      int first, cnt, both;
      logic [NL-1:0] all1;
      all1 = '1;
      bus.enable = 1'b0; bus.led = '0; bus.button = '0;
      tick(3);
      rst = 1'b0;
      chk("rst_score",  int'(bus.score), 0);
      chk("rst_misses", int'(bus.misses), 0);
      chk("rst_over",   int'(bus.game_over), 0);

      // first hit and its latency
      bus.enable = 1'b1;
      bus.led    = 18'h1;
      tick(2);
      bus.button = 18'h1;
      first = -1; cnt = 0;
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         if (t == 5) bus.button = '0;
         if (bus.hit_pulse) begin cnt++; if (first < 0) first = t; end
      end
      chk("hit_latency", first, 3);
      chk("hit_count", cnt, 1);
      chk("t1_score", int'(bus.score), 1);
      chk("t1_misses", int'(bus.misses), 0);

      // dark-LED miss, then double press on one lit LED
      bus.led = '0;
      tick(1);
      press(18'h10, 2);
      chk("t2_miss", int'(bus.misses), 1);
      bus.led = 18'h1;
      tick(1);
      press(18'h1, 2);
      press(18'h1, 2);
      chk("t2_score", int'(bus.score), 2);
      chk("t2_misses", int'(bus.misses), 2);

      // three lanes in one cycle: two hits and one miss
      bus.led = '0;
      tick(1);
      bus.led = 18'h84;
      bus.button = 18'h284;
      both = 0;
      for (int t = 1; t <= 7; t++) begin
         @(negedge clk);
         if (t == 2) bus.button = '0;
         if (bus.hit_pulse && bus.miss_pulse) both++;
      end
      chk("t3_both_pulses", both, 1);
      chk("t3_score", int'(bus.score), 4);
      chk("t3_misses", int'(bus.misses), 3);

      // single hits up to 40, level steps at 10/20/30 and holds at 3
      for (int s = 5; s <= 40; s++) begin
         do_hit(s % NL);
         if (s == 9)  chk("lvl_at9",  int'(bus.level), 0);
         if (s == 10) chk("lvl_at10", int'(bus.level), 1);
         if (s == 30) chk("lvl_at30", int'(bus.level), 3);
      end
      chk("t4_score", int'(bus.score), 40);
      chk("t4_level", int'(bus.level), 3);

      // pause: press while paused, and enable dropping on the scoring cycle
      bus.led = '0;
      tick(1);
      bus.led = 18'h8;
      bus.enable = 1'b0;
      tick(1);
      press(18'h8, 2);
      bus.enable = 1'b1;
      tick(2);
      bus.button = 18'h8;
      tick(2);
      bus.enable = 1'b0;
      tick(1);
      bus.button = '0;
      tick(4);
      chk("pause_score", int'(bus.score), 40);
      chk("pause_misses", int'(bus.misses), 3);
      bus.enable = 1'b1;
      tick(2);
      press(18'h8, 2);
      chk("resume_score", int'(bus.score), 41);

      // game over on the fifth miss, then frozen
      bus.led = '0;
      tick(1);
      press(18'h20, 2);
      chk("over_not_yet", int'(bus.game_over), 0);
      press(18'h40, 2);
      chk("over_misses", int'(bus.misses), 5);
      chk("over_flag", int'(bus.game_over), 1);
      press(18'h2, 2);
      bus.enable = 1'b0; tick(2);
      bus.enable = 1'b1; tick(2);
      press(18'h2, 2);
      chk("frozen_score", int'(bus.score), 41);
      chk("frozen_misses", int'(bus.misses), 5);

      // reset out of OVER; IDLE ignores presses
      bus.enable = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("rst2_score", int'(bus.score), 0);
      chk("rst2_level", int'(bus.level), 0);
      chk("rst2_over", int'(bus.game_over), 0);
      bus.led = 18'h1;
      press(18'h1, 2);
      chk("idle_ignored", int'(bus.score), 0);

      // all 18 lanes hit per round: one level step per update, score saturates
      bus.enable = 1'b1;
      tick(2);
      for (int r = 1; r <= 60; r++) begin
         bus.led = '0;
         tick(1);
         bus.led = all1;
         press(all1, 2);
         if (r == 1) begin
            chk("wide_score", int'(bus.score), 18);
            chk("wide_level_step", int'(bus.level), 1);
         end
      end
      chk("sat_score", int'(bus.score), 1023);
      chk("sat_misses", int'(bus.misses), 0);
      chk("sat_level", int'(bus.level), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
